// File: rtl/out_rr_scheduler_if.sv
// Merged output bus of out_rr_scheduler: one word plus source id, valid/ready handshake.
interface out_rr_scheduler_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_id;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_id, output m_valid, input m_ready);
  modport slave  (input m_data, input m_id, input m_valid, output m_ready);
endinterface

// File: rtl/out_rr_scheduler.sv
// Four-channel round-robin merger: per-channel FIFOs, rotating-priority grant,
// registered output stage with valid/ready, sticky per-channel overflow flags.
module out_rr_scheduler #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [DATA_W-1:0]    in_0,
  input  logic [DATA_W-1:0]    in_1,
  input  logic [DATA_W-1:0]    in_2,
  input  logic [DATA_W-1:0]    in_3,
  input  logic                 in_valid_0,
  input  logic                 in_valid_1,
  input  logic                 in_valid_2,
  input  logic                 in_valid_3,
  output logic [3:0]           overflow_out,
  out_rr_scheduler_if.master   m
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [DATA_W-1:0]   in_data [NCH];
  logic [NCH-1:0]      in_valid;
  logic [DATA_W-1:0]   mem [NCH][DEPTH];
  logic [PTR_W-1:0]    wr_ptr [NCH];
  logic [PTR_W-1:0]    rd_ptr [NCH];
  logic [NCH-1:0]      empty_c;
  logic [NCH-1:0]      full_c;
  logic [NCH-1:0]      pop_c;
  logic [NCH-1:0]      push_c;
  logic [1:0]          last_grant;
  logic [1:0]          gnt_idx_c;
  logic                gnt_c;
  logic                free_c;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          id_q;

  assign in_data[0] = in_0;
  assign in_data[1] = in_1;
  assign in_data[2] = in_2;
  assign in_data[3] = in_3;
  assign in_valid   = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  // Wrap bit differs with equal index bits => full.
  always_comb begin
    empty_c = '0;
    full_c  = '0;
    for (int n = 0; n < NCH; n++) begin
      empty_c[n] = (wr_ptr[n] == rd_ptr[n]);
      full_c[n]  = (wr_ptr[n][AW] != rd_ptr[n][AW]) &&
                   (wr_ptr[n][AW-1:0] == rd_ptr[n][AW-1:0]);
    end
  end

  // Rotating-priority search starting one past the last granted channel.
  always_comb begin
    logic [1:0] cand;
    cand      = '0;
    gnt_c     = 1'b0;
    gnt_idx_c = last_grant;
    pop_c     = '0;
    free_c    = (state == IDLE) || m.m_ready;
    for (int k = 1; k <= NCH; k++) begin
      cand = last_grant + 2'(k);
      if (!gnt_c && !empty_c[cand]) begin
        gnt_c     = 1'b1;
        gnt_idx_c = cand;
      end
    end
    if (free_c && gnt_c) pop_c[gnt_idx_c] = 1'b1;
    push_c = in_valid & (~full_c | pop_c);
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int n = 0; n < NCH; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (push_c[n]) wr_ptr[n] <= wr_ptr[n] + PTR_W'(1);
        if (pop_c[n])  rd_ptr[n] <= rd_ptr[n] + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk_in) begin
    for (int n = 0; n < NCH; n++) begin
      if (push_c[n]) mem[n][wr_ptr[n][AW-1:0]] <= in_data[n];
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) overflow_out <= '0;
    else           overflow_out <= overflow_out | (in_valid & ~push_c);
  end

  // Output stage FSM: IDLE = nothing presented, SEND = word presented.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      data_q     <= '0;
      id_q       <= '0;
    end else begin
      if (free_c && gnt_c) begin
        data_q     <= mem[gnt_idx_c][rd_ptr[gnt_idx_c][AW-1:0]];
        id_q       <= gnt_idx_c;
        last_grant <= gnt_idx_c;
      end
      case (state)
        IDLE:    if (gnt_c) state <= SEND;
        SEND:    if (m.m_ready && !gnt_c) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m.m_data  = data_q;
  assign m.m_id    = id_q;
  assign m.m_valid = (state == SEND);

endmodule

// File: tb/tb_out_rr_scheduler.sv
// Bench for out_rr_scheduler: directed vector table, hand sequences for corner
// cases, and randomized traffic compared against a queue-based reference model.
module tb_out_rr_scheduler;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk_in   = 1'b0;
  logic              reset_in = 1'b1;
  logic [3:0]        vld = '0;
  logic [31:0]       din = '0;
  logic              rdy = 1'b0;
  logic [DATA_W-1:0] in_0, in_1, in_2, in_3;
  logic              in_valid_0, in_valid_1, in_valid_2, in_valid_3;
  logic [3:0]        overflow_out;

  out_rr_scheduler_if #(.DATA_W(DATA_W)) bus ();

  assign in_0 = din[7:0];
  assign in_1 = din[15:8];
  assign in_2 = din[23:16];
  assign in_3 = din[31:24];
  assign in_valid_0 = vld[0];
  assign in_valid_1 = vld[1];
  assign in_valid_2 = vld[2];
  assign in_valid_3 = vld[3];
  assign bus.m_ready = rdy;

  out_rr_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .in_0         (in_0),
    .in_1         (in_1),
    .in_2         (in_2),
    .in_3         (in_3),
    .in_valid_0   (in_valid_0),
    .in_valid_1   (in_valid_1),
    .in_valid_2   (in_valid_2),
    .in_valid_3   (in_valid_3),
    .overflow_out (overflow_out),
    .m            (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-channel queues and the presented word.
  logic [7:0] q [4][$];
  logic       mv;
  logic [1:0] mid;
  logic [7:0] mdata;
  int         lg;
  logic [3:0] ov;
  logic [7:0] got [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) q[c].delete();
    mv = 1'b0; mid = 2'd0; mdata = 8'd0; lg = 3; ov = 4'd0;
  endfunction

  function automatic void model_update(input logic [3:0] v, input logic [31:0] d, input logic r);
    bit found;
    found = 1'b0;
    if (!mv || r) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (lg + k) % 4;
        if (!found && q[c].size() > 0) begin
          found = 1'b1;
          mdata = q[c].pop_front();
          mid   = 2'(c);
          lg    = c;
        end
      end
      mv = found;
    end
    for (int c = 0; c < 4; c++) begin
      if (v[c]) begin
        if (q[c].size() < DEPTH) q[c].push_back(d[8*c +: 8]);
        else ov[c] = 1'b1;
      end
    end
  endfunction

  // One clock: log accepted word, advance model at the edge, compare after it.
  task automatic step();
    if (bus.m_valid && rdy && reset_in) got.push_back(bus.m_data);
    @(posedge clk_in);
    if (!reset_in) model_reset();
    else model_update(vld, din, rdy);
    #1;
    chk("model_valid", 32'(bus.m_valid), 32'(mv));
    chk("model_ovf", 32'(overflow_out), 32'(ov));
    if (mv) begin
      chk("model_id", 32'(bus.m_id), 32'(mid));
      chk("model_data", 32'(bus.m_data), 32'(mdata));
    end
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    model_reset();
    vld = '0;
    step();
    reset_in = 1'b1;
  endtask

  typedef struct packed {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] din;
    logic        rdy;
    logic        ev;
    logic [1:0]  eid;
    logic [7:0]  ed;
    logic [3:0]  eov;
    logic        cd;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic ev, input logic [1:0] eid, input logic [7:0] ed,
                              input logic cd);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d; t.rdy = 1'b1;
    t.ev = ev; t.eid = eid; t.ed = ed; t.eov = 4'd0; t.cd = cd;
    tbl.push_back(t);
  endfunction

  initial begin
    // Reset held with random inputs
    #1;
    reset_in = 1'b0;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      vld = 4'($urandom); din = $urandom; rdy = 1'($urandom);
      step();
      chk("rst_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_data", 32'(bus.m_data), 32'd0);
      chk("rst_id", 32'(bus.m_id), 32'd0);
      chk("rst_ovf", 32'(overflow_out), 32'd0);
    end
    reset_in = 1'b1; vld = '0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_valid", 32'(bus.m_valid), 32'd0);
    end

    // Latency and round-robin vectors
    add(1, 4'b0000, 32'h0,         0, 2'd0, 8'h00, 1);
    add(0, 4'b0100, 32'h00A5_0000, 0, 2'd0, 8'h00, 0);
    add(0, 4'b0000, 32'h0,         1, 2'd2, 8'hA5, 1);
    add(0, 4'b0000, 32'h0,         0, 2'd0, 8'h00, 0);
    add(1, 4'b0000, 32'h0,         0, 2'd0, 8'h00, 1);
    add(0, 4'b1111, 32'h0403_0201, 0, 2'd0, 8'h00, 0);
    add(0, 4'b0000, 32'h0,         1, 2'd0, 8'h01, 1);
    add(0, 4'b0000, 32'h0,         1, 2'd1, 8'h02, 1);
    add(0, 4'b0000, 32'h0,         1, 2'd2, 8'h03, 1);
    add(0, 4'b0000, 32'h0,         1, 2'd3, 8'h04, 1);
    add(0, 4'b0000, 32'h0,         0, 2'd0, 8'h00, 0);
    add(0, 4'b1010, 32'h0403_0201, 0, 2'd0, 8'h00, 0);
    add(0, 4'b0000, 32'h0,         1, 2'd1, 8'h02, 1);
    add(0, 4'b0000, 32'h0,         1, 2'd3, 8'h04, 1);
    add(0, 4'b0000, 32'h0,         0, 2'd0, 8'h00, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      reset_in = !tbl[i].rst;
      if (tbl[i].rst) model_reset();
      vld = tbl[i].vld; din = tbl[i].din; rdy = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(bus.m_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow_out), 32'(tbl[i].eov));
      if (tbl[i].cd) begin
        chk($sformatf("tbl%0d_id", i), 32'(bus.m_id), 32'(tbl[i].eid));
        chk($sformatf("tbl%0d_data", i), 32'(bus.m_data), 32'(tbl[i].ed));
      end
    end
    reset_in = 1'b1;

    // Backpressure and overflow on channel 0
    do_reset();
    rdy = 1'b0;
    for (int w = 1; w <= 6; w++) begin
      vld = 4'b0001; din = 32'(w);
      step();
      if (w >= 2) chk("bp_hold_data", 32'(bus.m_data), 32'd1);
      chk("bp_ovf", 32'(overflow_out), (w == 6) ? 32'd1 : 32'd0);
    end
    vld = '0; got.delete(); rdy = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("bp_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("bp_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(i + 1));
    chk("bp_ovf_sticky", 32'(overflow_out), 32'd1);

    // Full FIFO with simultaneous pop and write
    do_reset();
    rdy = 1'b0;
    for (int w = 0; w < 5; w++) begin
      vld = 4'b0010; din = 32'(8'h10 + w) << 8;
      step();
    end
    chk("full_ovf_a", 32'(overflow_out), 32'd0);
    chk("full_head", 32'(bus.m_data), 32'h10);
    got.delete(); rdy = 1'b1;
    for (int w = 5; w < 13; w++) begin
      vld = 4'b0010; din = 32'(8'h10 + w) << 8;
      step();
    end
    vld = '0;
    for (int i = 0; i < 8; i++) step();
    chk("full_count", 32'(got.size()), 32'd13);
    for (int i = 0; i < 13; i++)
      chk("full_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(8'h10 + i));
    chk("full_ovf_b", 32'(overflow_out[1]), 32'd0);

    // Asynchronous reset mid-operation
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vld = 4'b1111; din = $urandom;
      step();
    end
    vld = '0;
    chk("mid_pre_valid", 32'(bus.m_valid), 32'd1);
    chk("mid_pre_ovf", 32'(overflow_out), 32'hF);
    #2;
    reset_in = 1'b0;
    model_reset();
    #1;
    chk("mid_async_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_async_ovf", 32'(overflow_out), 32'd0);
    step();
    step();
    reset_in = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_stale", 32'(bus.m_valid), 32'd0);
    end
    vld = 4'b1111; din = $urandom;
    step();
    vld = '0;
    step();
    chk("mid_first_valid", 32'(bus.m_valid), 32'd1);
    chk("mid_first_id", 32'(bus.m_id), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_in = 1'b0;
        model_reset();
      end else begin
        reset_in = 1'b1;
      end
      vld = 4'($urandom) & 4'($urandom | (((i / 500) % 2 == 1) ? 32'hF : 32'h0));
      din = $urandom;
      rdy = ((i / 250) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    reset_in = 1'b1; vld = '0; rdy = 1'b1;
    for (int i = 0; i < 12; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
